// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the activity-based clock gate controller.
package clk_gate_pkg;

  localparam int unsigned OFF_CNT_W = 8;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } cg_state_t;

  localparam logic [OFF_CNT_W-1:0] OFF_CNT_MAX = 8'hFF;

endpackage

// File: rtl/clk_gate_timer.sv
// Loadable down-counter shared by the wake-settle and idle-hysteresis phases.
module clk_gate_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Drives the ICG enable from requester activity with wake settle and idle hysteresis.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_DLY = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     gnt,
  input  logic                 force_on,
  input  logic                 cfg_auto_en,
  input  logic [CNT_W-1:0]     cfg_idle_thr,
  input  logic                 cnt_clr,
  output logic                 gate_en,
  output logic [1:0]           state_o,
  output logic [OFF_CNT_W-1:0] off_cnt
);

  cg_state_t        state;
  cg_state_t        state_nxt;
  logic             keep_c;
  logic             tmr_zero_c;
  logic             tmr_load;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             off_inc;

  // Anything that wants the clock running; overrides behave like a held request.
  assign keep_c = (|req) | force_on | ~cfg_auto_en;

  clk_gate_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:  if (keep_c) state_nxt = WAKE;
      WAKE: if (tmr_zero_c) state_nxt = ON;
      ON:   if (!keep_c) state_nxt = IDLE;
      IDLE: begin
        if (keep_c) begin
          state_nxt = ON;
        end else if (tmr_zero_c) begin
          state_nxt = OFF;
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  // Timer control and gate-off event; idle threshold is sampled only on IDLE entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    off_inc  = 1'b0;
    unique case (state)
      OFF: begin
        if (keep_c) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(WAKE_DLY - 1);
        end
      end
      WAKE: tmr_dec = 1'b1;
      ON: begin
        if (!keep_c) begin
          tmr_load = 1'b1;
          tmr_val  = cfg_idle_thr;
        end
      end
      IDLE: begin
        if (!keep_c) begin
          if (tmr_zero_c) begin
            off_inc = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered ICG enable, tracks the next state so it always equals (state != OFF).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gate_en <= 1'b0;
    end else begin
      gate_en <= (state_nxt != OFF);
    end
  end

  // Saturating gate-off counter; clear beats increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      off_cnt <= '0;
    end else if (cnt_clr) begin
      off_cnt <= '0;
    end else if (off_inc && (off_cnt != OFF_CNT_MAX)) begin
      off_cnt <= off_cnt + OFF_CNT_W'(1);
    end
  end

  assign gnt     = req & {N_REQ{state == ON}};
  assign state_o = state;

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Activity-based controller that drives the enable of the team's `clock_gating` block, i.e. the ICG in front of the gated 8-bit datapath.
- Collects up to N_REQ requesters and wakes the gated clock on any request.
- Grants requesters only after a wake settle delay has elapsed.
- Gates the clock off after a programmable idle hysteresis.
- Sits in the always-on clock domain next to the ICG instance.

Parameters:
- N_REQ, 4: number of requesters.
- CNT_W, 8: width of the idle threshold and internal timer.
- WAKE_DLY, 2: cycles gate_en is high before any grant is given; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  free-running always-on clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester activity request, level, held until done.
- gnt  out  N_REQ  per-requester grant; gated clock is running and settled.
- force_on  in  1  keep the clock enabled regardless of activity.
- cfg_auto_en  in  1  1 = auto gating allowed; 0 = clock held on.
- cfg_idle_thr  in  CNT_W  idle cycles before gating off.
- cnt_clr  in  1  synchronous clear of off_cnt.
- gate_en  out  1  registered enable to the clock_gating en input.
- state_o  out  2  current FSM state: 0 OFF, 1 WAKE, 2 ON, 3 IDLE.
- off_cnt  out  8  saturating count of ON/IDLE->OFF transitions.

Behaviour:
- Reset (async, rstn=0):
  - state=OFF, gate_en=0, gnt=0, off_cnt=0, timer=0.
  - Asserting rstn mid-operation forces this immediately, with no handshake.
- Define keep = |req | force_on | !cfg_auto_en.
- gate_en is a flop output equal to (state!=OFF), so it is glitch-free for the ICG latch.
- gnt[i] = req[i] && state==ON. This is combinational from the registered state; gnt is 0 in every other state.
- OFF:
  - keep=1 -> WAKE, timer loads WAKE_DLY-1.
  - Otherwise stay in OFF.
- WAKE:
  - Lasts exactly WAKE_DLY cycles (timer==0 -> ON, else timer--).
  - Not abortable: req dropping here still goes to ON.
- ON:
  - keep=0 -> IDLE, timer loads cfg_idle_thr (sampled at this edge only).
  - Otherwise stay in ON.
- IDLE:
  - keep=1 -> ON; the next cycle grants again with no wake delay.
  - Else timer==0 -> OFF and off_cnt increments, saturating at 255.
  - Else timer--.
  - IDLE lasts cfg_idle_thr+1 cycles when undisturbed; cfg_idle_thr=0 gives 1 IDLE cycle.
- Latency:
  - req rise sampled in OFF -> gate_en high after that edge.
  - gnt high WAKE_DLY cycles after gate_en rises.
  - Last req drop sampled in ON -> gate_en low cfg_idle_thr+2 edges later.
- Simultaneous events:
  - cnt_clr has priority over increment on the same edge.
  - cfg changes mid-countdown have no effect until the next IDLE entry.
  - cfg_auto_en=0 or force_on=1 acts exactly like a held request but produces no gnt.

Decomposition:
- Shared package clk_gate_pkg holds:
  - typedef cg_state_t, 2-bit enum OFF/WAKE/ON/IDLE;
  - constant OFF_CNT_MAX=8'hFF.
- One sub-module, clk_gate_timer: a CNT_W-bit loadable down-counter with load, load_val, dec and a zero flag. It is shared by the WAKE and IDLE states.
- The ICG itself (clock_gating) is instantiated by the parent, not inside this block.

Test Plan (WAKE_DLY=2, cfg_idle_thr=4, cfg_auto_en=1, clk period 10ns):
- Reset: rstn=0 for 10ns with req=4'hF -> gate_en=0, gnt=0, state_o=0, off_cnt=0 throughout reset.
- Wake: req=4'b0001 at t0 in OFF -> gate_en=1 after the next edge; state_o=1 for 2 cycles; then gnt=4'b0001, state_o=2.
- Idle gate-off:
  - drop req in ON -> state_o=3 for exactly 5 cycles, then gate_en=0, off_cnt=1;
  - repeat with cfg_idle_thr=0 -> 1 IDLE cycle.
- Re-request in IDLE: req=4'b0100 on the 3rd IDLE cycle -> state_o=2 next cycle, gnt=4'b0100 with no WAKE, off_cnt unchanged.
- Overrides:
  - force_on=1 with req=0 from OFF -> WAKE then ON with gnt=0, gate_en stays 1 indefinitely;
  - cfg_auto_en=0 gives the same result;
  - releasing it -> OFF after 6 edges.
- Counter/reset corner cases:
  - 260 gate-off cycles -> off_cnt=255 saturated;
  - cnt_clr together with a gate-off edge -> off_cnt=0;
  - rstn=0 asserted during WAKE -> gate_en=0 immediately, asynchronously.
